// File: rtl/hop_perm_seq_if.sv
// +--------------------------------------------------------------------------+
// | hop_perm_seq_if : start/busy/done handshake bundle for hop_perm_seq.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

interface hop_perm_seq_if;
    logic        start;
    logic [4:0]  perm_in_5;
    logic [13:0] perm_in_13;
    logic        busy;
    logic        done;
    logic [4:0]  perm_out;

    modport master (
        output start,
        output perm_in_5,
        output perm_in_13,
        input  busy,
        input  done,
        input  perm_out
    );

    modport slave (
        input  start,
        input  perm_in_5,
        input  perm_in_13,
        output busy,
        output done,
        output perm_out
    );
endinterface

`default_nettype wire

// File: rtl/hop_perm_seq.sv
// +--------------------------------------------------------------------------+
// | hop_perm_seq : sequential PERM5 butterfly controller, one shared stage   |
// | walked P13..P0. HOP_PERM_SEQ_DUAL_EN applies two stages per RUN cycle.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module hop_perm_seq #(
    parameter int STAGES = 14
) (
    input  wire             clk,
    input  wire             rst,
    hop_perm_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(STAGES - 1);
`ifdef HOP_PERM_SEQ_DUAL_EN
    localparam logic [3:0] C_STEP     = 4'd2;
    localparam logic [3:0] C_CNT_LAST = 4'd1;
`else
    localparam logic [3:0] C_STEP     = 4'd1;
    localparam logic [3:0] C_CNT_LAST = 4'd0;
`endif

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [4:0]  r_work;
    logic [13:0] r_ctrl;
    logic [4:0]  r_perm_out;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [4:0]  w_work_nxt;
    logic [13:0] w_ctrl_nxt;
    logic [4:0]  w_perm_out_nxt;
    logic [4:0]  w_stage_a;
    logic [4:0]  w_run_work;
    logic        w_last;

    // One butterfly stage: swap the bit pair wired to control bit idx when en=1.
    function automatic logic [4:0] f_stage(
        input logic [4:0] w,
        input logic [3:0] idx,
        input logic       en
    );
        logic [2:0] lo;
        logic [2:0] hi;
        logic [4:0] r;
        case (idx)
            4'd0:    begin lo = 3'd0; hi = 3'd1; end
            4'd1:    begin lo = 3'd2; hi = 3'd3; end
            4'd2:    begin lo = 3'd1; hi = 3'd2; end
            4'd3:    begin lo = 3'd3; hi = 3'd4; end
            4'd4:    begin lo = 3'd0; hi = 3'd4; end
            4'd5:    begin lo = 3'd1; hi = 3'd3; end
            4'd6:    begin lo = 3'd0; hi = 3'd2; end
            4'd7:    begin lo = 3'd3; hi = 3'd4; end
            4'd8:    begin lo = 3'd1; hi = 3'd4; end
            4'd9:    begin lo = 3'd0; hi = 3'd3; end
            4'd10:   begin lo = 3'd2; hi = 3'd4; end
            4'd11:   begin lo = 3'd1; hi = 3'd3; end
            4'd12:   begin lo = 3'd0; hi = 3'd3; end
            4'd13:   begin lo = 3'd1; hi = 3'd2; end
            default: begin lo = 3'd0; hi = 3'd0; end
        endcase
        r = w;
        if (en) begin
            r[lo] = w[hi];
            r[hi] = w[lo];
        end
        return r;
    endfunction

    assign w_stage_a = f_stage(r_work, r_cnt, r_ctrl[r_cnt]);
`ifdef HOP_PERM_SEQ_DUAL_EN
    assign w_run_work = f_stage(w_stage_a, r_cnt - 4'd1, r_ctrl[r_cnt - 4'd1]);
`else
    assign w_run_work = w_stage_a;
`endif
    assign w_last = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= C_CNT_INIT;
            r_work     <= 5'd0;
            r_ctrl     <= 14'd0;
            r_perm_out <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_work     <= w_work_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_perm_out <= w_perm_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_work_nxt     = r_work;
        w_ctrl_nxt     = r_ctrl;
        w_perm_out_nxt = r_perm_out;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_work_nxt  = bus.perm_in_5;
                    w_ctrl_nxt  = bus.perm_in_13;
                    w_cnt_nxt   = C_CNT_INIT;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_work_nxt = w_run_work;
                if (w_last) begin
                    // Result register loads on entry to DONE so it is valid alongside the done pulse.
                    w_perm_out_nxt = w_run_work;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - C_STEP;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.perm_out = r_perm_out;

endmodule

`default_nettype wire

// File: tb/tb_hop_perm_seq.sv
// +--------------------------------------------------------------------------+
// | tb_hop_perm_seq : vector table plus handshake corner sequences.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hop_perm_seq;

`ifdef HOP_PERM_SEQ_DUAL_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 15;
`endif

    typedef struct {
        logic [13:0] ctrl;
        logic [4:0]  din;
        logic [4:0]  exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [4:0] exp_q[$];
    vec_t vecs[8];

    hop_perm_seq_if bus ();

    hop_perm_seq #(.STAGES(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Reference: follow bit swaps from P13 down to P0.
    function automatic logic [4:0] model(input logic [13:0] p, input logic [4:0] d);
        int lo [14];
        int hi [14];
        logic [4:0] r;
        logic t;
        lo = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
        hi = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};
        r = d;
        for (int k = 13; k >= 0; k--) begin
            if (p[k]) begin
                t        = r[lo[k]];
                r[lo[k]] = r[hi[k]];
                r[hi[k]] = t;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("perm_out_at_done", 32'(bus.perm_out), 32'(e));
            end
        end
    end

    task automatic run_vec(input vec_t v, input string nm);
        int  done_c;
        bit  busy_ok;
        bus.perm_in_13 = v.ctrl;
        bus.perm_in_5  = v.din;
        bus.start      = 1'b1;
        exp_q.push_back(v.exp);
        done_c  = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start      = 1'b0;
                bus.perm_in_13 = 14'($urandom);
                bus.perm_in_5  = 5'($urandom);
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                done_c = c;
                break;
            end
        end
        check({nm, "_done_cycle"}, 32'(done_c), 32'(LAT));
        check({nm, "_busy_window"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({nm, "_idle_after"}, 32'(bus.busy), 32'd0);
        check({nm, "_held"}, 32'(bus.perm_out), 32'(v.exp));
    endtask

    initial begin
        vec_t a;
        vec_t b;
        vec_t c2;
        int   nd;
        int   d1;
        int   d2;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{ctrl: 14'h0000, din: 5'b10110, exp: 5'b10110};
        vecs[1] = '{ctrl: 14'h0001, din: 5'b00001, exp: 5'b00010};
        vecs[2] = '{ctrl: 14'h2000, din: 5'b00010, exp: 5'b00100};
        vecs[3] = '{ctrl: 14'h3FFF, din: 5'b00001, exp: 5'b01000};
        for (int i = 4; i < 8; i++) begin
            vecs[i].ctrl = 14'($urandom);
            vecs[i].din  = 5'($urandom);
            vecs[i].exp  = model(vecs[i].ctrl, vecs[i].din);
        end

        // Reset with start asserted: reset must win.
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.perm_in_5  = 5'h1F;
        bus.perm_in_13 = 14'h3FFF;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_perm_out", 32'(bus.perm_out), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Starts during a run are ignored; start in the IDLE after done is taken.
        a.ctrl = 14'h1234; a.din = 5'b01101; a.exp = model(a.ctrl, a.din);
        b.ctrl = 14'h3FFF; b.din = 5'b11110; b.exp = model(b.ctrl, b.din);
        c2.ctrl = 14'h0A5C; c2.din = 5'b00111; c2.exp = model(c2.ctrl, c2.din);
        bus.perm_in_13 = a.ctrl;
        bus.perm_in_5  = a.din;
        bus.start      = 1'b1;
        exp_q.push_back(a.exp);
        nd = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 2 * LAT + 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 3 || c == LAT - 1) begin
                bus.start      = 1'b1;
                bus.perm_in_13 = b.ctrl;
                bus.perm_in_5  = b.din;
            end
            if (c == LAT + 1) begin
                bus.start      = 1'b1;
                bus.perm_in_13 = c2.ctrl;
                bus.perm_in_5  = c2.din;
                exp_q.push_back(c2.exp);
            end
            if (bus.done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = c; else d2 = c;
            end
        end
        check("ign_done_count", 32'(nd), 32'd2);
        check("ign_first_done", 32'(d1), 32'(LAT));
        check("ign_second_done", 32'(d2), 32'(2 * LAT + 1));

        // start held high: a new run on every IDLE cycle, inputs re-captured.
        bus.perm_in_13 = a.ctrl;
        bus.perm_in_5  = a.din;
        bus.start      = 1'b1;
        exp_q.push_back(a.exp);
        nd = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 2 * LAT + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.perm_in_13 = c2.ctrl;
                bus.perm_in_5  = c2.din;
            end
            if (c == LAT + 1) exp_q.push_back(c2.exp);
            if (c == LAT + 2) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = c; else d2 = c;
            end
        end
        check("hold_done_count", 32'(nd), 32'd2);
        check("hold_first_done", 32'(d1), 32'(LAT));
        check("hold_second_done", 32'(d2), 32'(2 * LAT + 1));

        // Reset mid-run discards the run; a fresh start completes normally.
        bus.perm_in_13 = b.ctrl;
        bus.perm_in_5  = b.din;
        bus.start      = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 7) rst = 1'b1;
            if (c == 8) begin
                rst = 1'b0;
                check("midrst_busy", 32'(bus.busy), 32'd0);
                check("midrst_done", 32'(bus.done), 32'd0);
                check("midrst_perm_out", 32'(bus.perm_out), 32'd0);
            end
        end
        @(negedge clk);
        run_vec(vecs[3], "after_rst");

        repeat (LAT + 4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/hop_perm_seq.md
Name: hop_perm_seq

Overview:
- Sequential controller for the 5-bit hop-selection permutation (PERM5).
- Holds one shared butterfly stage and applies the 14 control-bit stages in order, one per clock, instead of 14 parallel butterflies.
- Sits between the hop-kernel adder/XOR front end and the register-bank index stage.
- Start/busy/done handshake; the result is registered and held until the next completed run.

Parameters:
- STAGES, 14, number of butterfly stages, fixed by the permutation definition. Not user-tunable; exposed for the bench only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a permutation run; sampled only in IDLE.
- perm_in_5  input  5  word to permute; captured on an accepted start.
- perm_in_13  input  14  butterfly control bits P13..P0; captured on an accepted start.
- busy  output  1  high while a run is in progress (RUN or DONE state).
- done  output  1  one-cycle pulse; perm_out is valid from that cycle on.
- perm_out  output  5  permuted word, registered, held until the next done.

Behaviour:
- Reset is synchronous and active-high. On rst:
  - state=IDLE, stage counter=13, working register=0.
  - busy=0, done=0, perm_out=5'b0.
  - rst overrides start and any run in progress: a mid-run reset discards that run.
- States:
  - IDLE: busy=0. If start=1, capture perm_in_5 into the working register and perm_in_13 into the control register, load counter=13, go to RUN.
  - RUN: busy=1. Each cycle apply stage P[counter] to the working register.
    - If counter==0, go to DONE.
    - Otherwise decrement the counter.
  - DONE: busy=1. Copy the working register to perm_out, pulse done=1 for this cycle only, return to IDLE.
- Stage order is P13 first, down to P0. Bit-pair swapped when the control bit is 1 (left unchanged when 0):
  - P13:{1,2}  P12:{0,3}  P11:{1,3}  P10:{2,4}  P9:{0,3}  P8:{1,4}  P7:{3,4}
  - P6:{0,2}  P5:{1,3}  P4:{0,4}  P3:{3,4}  P2:{1,2}  P1:{2,3}  P0:{0,1}
- Latency:
  - Start accepted at cycle 0.
  - RUN occupies cycles 1..14.
  - done=1 and the new perm_out appear at cycle 15.
  - busy is high for cycles 1..15.
- Back-to-back: start may be asserted in the cycle after done (IDLE). Throughput is one result per 16 cycles.
- start while busy=1 is ignored, with no queuing. Input changes after capture have no effect on the run in progress.
- start held high continuously: a new run is accepted on every IDLE cycle.
- perm_out changes only in the DONE cycle or on reset.

Optional Feature:
- Macro: HOP_PERM_SEQ_DUAL_EN.
- Defined: two butterfly stages are applied per RUN cycle: (P13,P12), (P11,P10), …, (P1,P0), counter stepping by 2.
  - RUN lasts 7 cycles, done at cycle 8, busy for cycles 1..8.
  - Stage order and results are identical to the single-stage build.
- Undefined: single-stage sequencing as described above.
- Port list is identical in both builds.

Test Plan:
- Identity: perm_in_13=14'h0000, perm_in_5=5'b10110, start at cycle 0 -> done at cycle 15, perm_out=5'b10110, busy high cycles 1..15.
- Last stage only: perm_in_13=14'h0001, perm_in_5=5'b00001 -> perm_out=5'b00010.
- First stage only: perm_in_13=14'h2000, perm_in_5=5'b00010 -> perm_out=5'b00100.
- All stages: perm_in_13=14'h3FFF, perm_in_5=5'b00001 -> perm_out=5'b01000. Repeat with HOP_PERM_SEQ_DUAL_EN defined -> same value with done at cycle 8.
- Ignored start: start pulses during cycles 3 and 9 with different inputs -> only one done at cycle 15, result from the cycle-0 inputs. A start at cycle 16 is accepted, giving done at cycle 31.
- Reset mid-run: rst at cycle 7 -> cycle 8 shows busy=0, done=0, perm_out=0. No done pulse follows, and a new start at cycle 9 completes with done at cycle 24.
